nested_irq_controller: RTL and testbench

NESTED_IRQ_CONTROLLER -- requirements
Module: nested_irq_controller

---
 rtl/irq_pkg.sv | 14 +
 rtl/nested_irq_controller_if.sv | 29 ++
 rtl/irq_prio_arbiter.sv | 35 +++
 rtl/nested_irq_controller.sv | 112 +++++++++++
 tb/tb_nested_irq_controller.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and nest-stack entry type for the nested IRQ controller
package irq_pkg;

  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
  localparam int          IDX_W          = 5;
  localparam int          PRIO_MAX_W     = 8;

  // Entries are stored at fixed width so the package stays independent of instance parameters.
  typedef struct packed {
    logic [IDX_W-1:0]      idx;
    logic [PRIO_MAX_W-1:0] prio;
  } stack_entry_t;

endpackage

// File: rtl/nested_irq_controller_if.sv
// rtl/nested_irq_controller_if.sv - core-facing request/trap bundle of the nested IRQ controller
interface nested_irq_controller_if #(
  parameter int N_IRQ      = 16,
  parameter int PRIO_W     = 2,
  parameter int NEST_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  logic                      exception_i;
  logic [N_IRQ-1:0]          irq_req_i;
  logic [N_IRQ-1:0]          mie_i;
  logic [N_IRQ*PRIO_W-1:0]   irq_prio_i;
  logic                      mret_i;
  logic                      irq_o;
  logic [N_IRQ-1:0]          irq_ret_o;
  logic [31:0]               irq_cause_o;
  logic [DEPTH_W-1:0]        irq_depth_o;

  modport master (
    output exception_i, irq_req_i, mie_i, irq_prio_i, mret_i,
    input  irq_o, irq_ret_o, irq_cause_o, irq_depth_o
  );

  modport slave (
    input  exception_i, irq_req_i, mie_i, irq_prio_i, mret_i,
    output irq_o, irq_ret_o, irq_cause_o, irq_depth_o
  );

endinterface

// File: rtl/irq_prio_arbiter.sv
// rtl/irq_prio_arbiter.sv - picks the most urgent masked source strictly above the current level
module irq_prio_arbiter
  import irq_pkg::*;
#(
  parameter int N_IRQ  = 16,
  parameter int PRIO_W = 2
) (
  input  logic [N_IRQ-1:0]        masked_i,
  input  logic [N_IRQ*PRIO_W-1:0] prio_i,
  input  logic                    level_vld_i,
  input  logic [PRIO_MAX_W-1:0]   level_i,
  output logic                    valid_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic [PRIO_MAX_W-1:0]   prio_o
);

  logic [PRIO_MAX_W-1:0] p;

  // Ascending scan with a strict compare keeps the lowest index on ties.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    prio_o  = '0;
    p       = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      p = PRIO_MAX_W'(prio_i[k*PRIO_W +: PRIO_W]);
      if (masked_i[k] && (!level_vld_i || (p > level_i)) && (!valid_o || (p > prio_o))) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(k);
        prio_o  = p;
      end
    end
  end

endmodule

// File: rtl/nested_irq_controller.sv
// rtl/nested_irq_controller.sv - priority-nesting interrupt controller with trap/return stack
module nested_irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ      = 16,
  parameter int PRIO_W     = 2,
  parameter int NEST_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  nested_irq_controller_if.slave bus
);

  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

  stack_entry_t          stack_q [NEST_DEPTH];
  stack_entry_t          stack_d [NEST_DEPTH];
  stack_entry_t          top_e;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  exc_q, exc_d;
  logic                  irq_q, irq_d;
  logic [N_IRQ-1:0]      ret_q, ret_d;
  logic [31:0]           cause_q, cause_d;

  logic [N_IRQ-1:0]      masked;
  logic                  level_vld;
  logic                  win_vld;
  logic [IDX_W-1:0]      win_idx;
  logic [PRIO_MAX_W-1:0] win_prio;
  logic                  exc_blk;
  logic                  do_pop;
  logic                  do_acc;

  assign masked    = bus.irq_req_i & bus.mie_i;
  assign level_vld = (depth_q != '0);

  always_comb begin
    top_e = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth_q) top_e = stack_q[i];
    end
  end

  irq_prio_arbiter #(
    .N_IRQ  (N_IRQ),
    .PRIO_W (PRIO_W)
  ) u_arb (
    .masked_i    (masked),
    .prio_i      (bus.irq_prio_i),
    .level_vld_i (level_vld),
    .level_i     (top_e.prio),
    .valid_o     (win_vld),
    .idx_o       (win_idx),
    .prio_o      (win_prio)
  );

  // A live or held exception freezes the stack; mret always outranks a new accept.
  assign exc_blk = bus.exception_i | exc_q;
  assign do_pop  = bus.mret_i & ~exc_blk & level_vld;
  assign do_acc  = win_vld & ~exc_blk & ~bus.mret_i & (depth_q != DEPTH_W'(NEST_DEPTH));

  always_comb begin
    exc_d   = exc_q;
    stack_d = stack_q;
    depth_d = depth_q;
    irq_d   = 1'b0;
    ret_d   = '0;
    cause_d = cause_q;
    if (bus.exception_i) begin
      exc_d = 1'b1;
    end else if (bus.mret_i) begin
      exc_d = 1'b0;
    end
    if (do_pop) begin
      depth_d = depth_q - DEPTH_W'(1);
      for (int k = 0; k < N_IRQ; k++) begin
        ret_d[k] = (top_e.idx == IDX_W'(k));
      end
    end else if (do_acc) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (DEPTH_W'(i) == depth_q) stack_d[i] = '{idx: win_idx, prio: win_prio};
      end
      depth_d = depth_q + DEPTH_W'(1);
      irq_d   = 1'b1;
      cause_d = IRQ_CAUSE_BASE + 32'(win_idx);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      depth_q <= '0;
      exc_q   <= 1'b0;
      irq_q   <= 1'b0;
      ret_q   <= '0;
      cause_q <= '0;
    end else begin
      stack_q <= stack_d;
      depth_q <= depth_d;
      exc_q   <= exc_d;
      irq_q   <= irq_d;
      ret_q   <= ret_d;
      cause_q <= cause_d;
    end
  end

  assign bus.irq_o       = irq_q;
  assign bus.irq_ret_o   = ret_q;
  assign bus.irq_cause_o = cause_q;
  assign bus.irq_depth_o = depth_q;

endmodule

// File: tb/tb_nested_irq_controller.sv
// tb/tb_nested_irq_controller.sv - vector-table and scoreboard bench for nested_irq_controller
module tb_nested_irq_controller;

  localparam logic [31:0] C  = 32'h8000_0010;
  localparam logic [15:0] M  = 16'hFFFF;
  localparam logic [15:0] B0 = 16'h0001;
  localparam logic [15:0] B2 = 16'h0004;
  localparam logic [15:0] B3 = 16'h0008;
  localparam logic [15:0] B5 = 16'h0020;
  localparam logic [15:0] B7 = 16'h0080;

  typedef struct {
    string       name;
    logic        irq;
    logic [15:0] ret;
    logic [31:0] cause;
    logic [3:0]  depth;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        exc;
    logic        mret;
    logic [15:0] req;
    logic [15:0] mie;
    logic        irq;
    logic [15:0] ret;
    logic [31:0] cause;
    logic [3:0]  depth;
  } vec_t;

  logic clk = 1'b0;
  logic rst_na, rst_nb;
  always #5 clk = ~clk;

  nested_irq_controller_if #(.N_IRQ(16), .PRIO_W(2), .NEST_DEPTH(4)) if_a ();
  nested_irq_controller_if #(.N_IRQ(16), .PRIO_W(2), .NEST_DEPTH(2)) if_b ();

  nested_irq_controller #(.N_IRQ(16), .PRIO_W(2), .NEST_DEPTH(4)) u_dut_a (
    .clk_i (clk), .rst_ni (rst_na), .bus (if_a)
  );
  nested_irq_controller #(.N_IRQ(16), .PRIO_W(2), .NEST_DEPTH(2)) u_dut_b (
    .clk_i (clk), .rst_ni (rst_nb), .bus (if_b)
  );

  exp_t sb_q[$];
  vec_t vecs_a[$];
  vec_t vecs_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input string n, input logic r, input logic e, input logic m,
                              input logic [15:0] rq, input logic [15:0] mk_mie, input logic i,
                              input logic [15:0] rt, input logic [31:0] c, input logic [3:0] d);
    vec_t v;
    v.name = n; v.rst_n = r; v.exc = e; v.mret = m; v.req = rq; v.mie = mk_mie;
    v.irq = i; v.ret = rt; v.cause = c; v.depth = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_pop(input logic irq, input logic [15:0] ret, input logic [31:0] cause,
                         input logic [3:0] depth);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got output with no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    check({e.name, ".irq"},   32'(irq),   32'(e.irq));
    check({e.name, ".ret"},   32'(ret),   32'(e.ret));
    check({e.name, ".cause"}, cause,      e.cause);
    check({e.name, ".depth"}, 32'(depth), 32'(e.depth));
  endtask

  task automatic apply(input bit use_b, input vec_t v);
    exp_t e;
    @(negedge clk);
    if (!use_b) begin
      rst_na = v.rst_n; if_a.exception_i = v.exc; if_a.mret_i = v.mret;
      if_a.irq_req_i = v.req; if_a.mie_i = v.mie;
    end else begin
      rst_nb = v.rst_n; if_b.exception_i = v.exc; if_b.mret_i = v.mret;
      if_b.irq_req_i = v.req; if_b.mie_i = v.mie;
    end
    e.name = v.name; e.irq = v.irq; e.ret = v.ret; e.cause = v.cause; e.depth = v.depth;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (!use_b) cmp_pop(if_a.irq_o, if_a.irq_ret_o, if_a.irq_cause_o, 4'(if_a.irq_depth_o));
    else        cmp_pop(if_b.irq_o, if_b.irq_ret_o, if_b.irq_cause_o, 4'(if_b.irq_depth_o));
  endtask

  initial begin
    logic [31:0] pa, pb;
    rst_na = 1'b0; rst_nb = 1'b0;
    if_a.exception_i = 1'b0; if_a.mret_i = 1'b0; if_a.irq_req_i = '0; if_a.mie_i = '0;
    if_b.exception_i = 1'b0; if_b.mret_i = 1'b0; if_b.irq_req_i = '0; if_b.mie_i = '0;
    // DUT A: src3=1, src7=3, src2=2, src5=2, all others 0
    pa = '0; pa[6 +: 2] = 2'd1; pa[14 +: 2] = 2'd3; pa[4 +: 2] = 2'd2; pa[10 +: 2] = 2'd2;
    // DUT B: src1=1, src2=2, src3=3
    pb = '0; pb[2 +: 2] = 2'd1; pb[4 +: 2] = 2'd2; pb[6 +: 2] = 2'd3;
    if_a.irq_prio_i = pa;
    if_b.irq_prio_i = pb;

    //                name            rst exc mret req      mie  irq ret cause depth
    vecs_a.push_back(mk("reset",        0, 0, 0, '0,      M,   0, '0, '0,   0));
    vecs_a.push_back(mk("idle",         1, 0, 0, '0,      M,   0, '0, '0,   0));
    vecs_a.push_back(mk("acc_s3",       1, 0, 0, B3,      M,   1, '0, C+3,  1));
    vecs_a.push_back(mk("hold_s3",      1, 0, 0, B3,      M,   0, '0, C+3,  1));
    vecs_a.push_back(mk("preempt_s7",   1, 0, 0, B3|B7,   M,   1, '0, C+7,  2));
    vecs_a.push_back(mk("hold_s7",      1, 0, 0, B3|B7,   M,   0, '0, C+7,  2));
    vecs_a.push_back(mk("mret_s7",      1, 0, 1, B3,      M,   0, B7, C+7,  1));
    vecs_a.push_back(mk("s3_no_retrig", 1, 0, 0, B3,      M,   0, '0, C+7,  1));
    vecs_a.push_back(mk("mret_s3",      1, 0, 1, '0,      M,   0, B3, C+7,  0));
    vecs_a.push_back(mk("idle2",        1, 0, 0, '0,      M,   0, '0, C+7,  0));
    vecs_a.push_back(mk("mret_empty",   1, 0, 1, '0,      M,   0, '0, C+7,  0));
    vecs_a.push_back(mk("tie_s2_s5",    1, 0, 0, B2|B5,   M,   1, '0, C+2,  1));
    vecs_a.push_back(mk("tie_hold",     1, 0, 0, B2|B5,   M,   0, '0, C+2,  1));
    vecs_a.push_back(mk("exc_pulse",    1, 1, 0, '0,      M,   0, '0, C+2,  1));
    vecs_a.push_back(mk("mret_clr_exc", 1, 0, 1, '0,      M,   0, '0, C+2,  1));
    vecs_a.push_back(mk("mret_pop_s2",  1, 0, 1, '0,      M,   0, B2, C+2,  0));
    vecs_a.push_back(mk("acc_s3b",      1, 0, 0, B3,      M,   1, '0, C+3,  1));
    vecs_a.push_back(mk("exc_and_mret", 1, 1, 1, '0,      M,   0, '0, C+3,  1));
    vecs_a.push_back(mk("mret_clr2",    1, 0, 1, '0,      M,   0, '0, C+3,  1));
    vecs_a.push_back(mk("mret_pop_s3",  1, 0, 1, '0,      M,   0, B3, C+3,  0));
    vecs_a.push_back(mk("exc_blk_acc",  1, 1, 0, B7,      M,   0, '0, C+3,  0));
    vecs_a.push_back(mk("exch_blk_acc", 1, 0, 0, B7,      M,   0, '0, C+3,  0));
    vecs_a.push_back(mk("mret_clr3",    1, 0, 1, B7,      M,   0, '0, C+3,  0));
    vecs_a.push_back(mk("acc_s7",       1, 0, 0, B7,      M,   1, '0, C+7,  1));
    vecs_a.push_back(mk("mret_pop_s7",  1, 0, 1, '0,      M,   0, B7, C+7,  0));
    vecs_a.push_back(mk("acc_s3c",      1, 0, 0, B3,      M,   1, '0, C+3,  1));
    vecs_a.push_back(mk("mret_vs_win",  1, 0, 1, B3|B7,   M,   0, B3, C+3,  0));
    vecs_a.push_back(mk("reeval_s7",    1, 0, 0, B3|B7,   M,   1, '0, C+7,  1));
    vecs_a.push_back(mk("s3_below",     1, 0, 0, B3|B7,   M,   0, '0, C+7,  1));
    vecs_a.push_back(mk("mret_pop_s7b", 1, 0, 1, '0,      M,   0, B7, C+7,  0));
    vecs_a.push_back(mk("acc_s3d",      1, 0, 0, B3,      M,   1, '0, C+3,  1));
    vecs_a.push_back(mk("acc_s7d",      1, 0, 0, B3|B7,   M,   1, '0, C+7,  2));
    vecs_a.push_back(mk("reset_mid",    0, 0, 0, B0,      M,   0, '0, '0,   0));
    vecs_a.push_back(mk("acc_s0",       1, 0, 0, B0,      M,   1, '0, C,    1));
    vecs_a.push_back(mk("hold_s0",      1, 0, 0, B0,      M,   0, '0, C,    1));
    vecs_a.push_back(mk("mask_s7",      1, 0, 0, B0|B7,   ~B7, 0, '0, C,    1));
    vecs_a.push_back(mk("unmask_s7",    1, 0, 0, B0|B7,   M,   1, '0, C+7,  2));

    foreach (vecs_a[i]) apply(1'b0, vecs_a[i]);

    // Depth-limited instance: fill the stack, then a more urgent source must wait for mret.
    vecs_b.push_back(mk("b_reset",      0, 0, 0, '0,       M, 0, '0,      '0,  0));
    vecs_b.push_back(mk("b_acc1",       1, 0, 0, 16'h0002, M, 1, '0,      C+1, 1));
    vecs_b.push_back(mk("b_acc2",       1, 0, 0, 16'h0006, M, 1, '0,      C+2, 2));
    for (int i = 0; i < 4; i++)
      vecs_b.push_back(mk("b_full_wait", 1, 0, 0, 16'h000E, M, 0, '0,     C+2, 2));
    vecs_b.push_back(mk("b_mret",       1, 0, 1, 16'h000E, M, 0, 16'h0004, C+2, 1));
    vecs_b.push_back(mk("b_acc3",       1, 0, 0, 16'h000E, M, 1, '0,      C+3, 2));
    vecs_b.push_back(mk("b_full_hold",  1, 0, 0, 16'h000E, M, 0, '0,      C+3, 2));

    foreach (vecs_b[i]) apply(1'b1, vecs_b[i]);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
